vc_weighted_lock_rr_arb: RTL

//  Parametrised weighted round-robin arbiter with packet lock and a consume handshake.

---
 rtl/vc_weighted_lock_rr_arb_pkg.sv | 12 +
 rtl/vc_weighted_lock_rr_arb_chain.sv | 27 ++
 rtl/vc_weighted_lock_rr_arb.sv | 102 ++++++++++
 3 files changed

// File: rtl/vc_weighted_lock_rr_arb_pkg.sv
// Shared types for the weighted lock round-robin arbiter.
// Classifies what a consumed beat does to the priority/burst state.
package vc_weighted_lock_rr_arb_pkg;

  typedef enum logic [1:0] {
    BEAT_NONE,    // no consume event, state holds
    BEAT_LOCK,    // owner keeps the grant, burst count untouched
    BEAT_HOLD,    // burst continues, owner keeps priority
    BEAT_ROTATE   // burst exhausted, priority moves to the next index
  } beat_e;

endpackage

// File: rtl/vc_weighted_lock_rr_arb_chain.sv
// Variable-priority arbiter chain: first requester at or above the one-hot prio, with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module vc_weighted_lock_rr_arb_chain #(
  parameter int p_num_reqs = 4
) (
  input  logic [p_num_reqs-1:0] prio,
  input  logic [p_num_reqs-1:0] reqs,
  output logic [p_num_reqs-1:0] grants
);

  // Walk the vector twice so the search starting at prio can wrap past the top index.
  always_comb begin
    logic active;
    logic done;
    grants = '0;
    active = 1'b0;
    done   = 1'b0;
    for (int k = 0; k < 2 * p_num_reqs; k++) begin
      if (prio[k % p_num_reqs]) active = 1'b1;
      if (active && !done && reqs[k % p_num_reqs]) begin
        grants[k % p_num_reqs] = 1'b1;
        done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_weighted_lock_rr_arb.sv
// Weighted round-robin arbiter with packet lock; grants are combinational (zero latency).
// State advances only when a grant is consumed (en); with en low everything holds.
module vc_weighted_lock_rr_arb
  import vc_weighted_lock_rr_arb_pkg::*;
#(
  parameter int                    p_num_reqs             = 4,
  parameter int                    p_weight_nbits         = 3,
  parameter logic [p_num_reqs-1:0] p_priority_reset_value = p_num_reqs'(1)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [p_num_reqs-1:0]                  reqs,
  input  logic [p_num_reqs-1:0]                  locks,
  input  logic [p_num_reqs*p_weight_nbits-1:0]   weights,
  input  logic                                   en,
  output logic [p_num_reqs-1:0]                  grants,
  output logic [$clog2(p_num_reqs)-1:0]          grant_idx,
  output logic                                   locked
);

  localparam int c_idx_nbits = $clog2(p_num_reqs);
  localparam int W           = p_weight_nbits;

  logic [p_num_reqs-1:0] prio;
  logic [W-1:0]          cnt;
  logic [p_num_reqs-1:0] arb_grants;
  logic [p_num_reqs-1:0] rot_grants;
  logic [W-1:0]          g_weight;
  logic [W-1:0]          wmax;
  logic [W:0]            n;
  logic                  consume;
  beat_e                 beat;

  vc_weighted_lock_rr_arb_chain #(.p_num_reqs(p_num_reqs)) u_chain (
    .prio   (prio),
    .reqs   (reqs),
    .grants (arb_grants)
  );

  // While locked, only the owner can be granted; everyone else waits even if it drops req.
  always_comb begin
    grants = '0;
    if (!reset) grants = locked ? (prio & reqs) : arb_grants;
  end

  always_comb begin
    grant_idx = '0;
    g_weight  = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (grants[i]) begin
        grant_idx = c_idx_nbits'(i);
        g_weight  = weights[i*W +: W];
      end
    end
  end

  assign consume    = (|grants) && en;
  assign rot_grants = {grants[p_num_reqs-2:0], grants[p_num_reqs-1]};
  assign wmax       = (g_weight == '0) ? W'(1) : g_weight;
  // A burst only continues if the winner already held priority with beats in flight.
  assign n          = ((|(prio & grants)) && (cnt != '0)) ? ({1'b0, cnt} + (W+1)'(1)) : (W+1)'(1);

  always_comb begin
    beat = BEAT_NONE;
    if (consume) begin
      if (|(locks & grants))     beat = BEAT_LOCK;
      else if (n >= {1'b0, wmax}) beat = BEAT_ROTATE;
      else                       beat = BEAT_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio   <= p_priority_reset_value;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      case (beat)
        BEAT_LOCK: begin
          prio   <= grants;
          locked <= 1'b1;
        end
        BEAT_HOLD: begin
          prio   <= grants;
          cnt    <= n[W-1:0];
          locked <= 1'b0;
        end
        BEAT_ROTATE: begin
          prio   <= rot_grants;
          cnt    <= '0;
          locked <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  a_grants_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grants));
  a_grants_subset:  assert property (@(posedge clk) disable iff (reset) (grants & ~reqs) == '0);
  a_locked_prio:    assert property (@(posedge clk) disable iff (reset) locked |-> $onehot(prio));

endmodule
